int_arbiter: RTL and testbench
==============================

# int_arbiter

Interrupt arbiter and sequencer in front of the machine-mode CSR register file. It collects N_SRC external interrupt lines into edge-captured pending bits and masks them with a software-writable enable mask. It selects one source by fixed priority, drives the single `int_req` line that the CSR file qualifies with `mstatus.MIE`/`mie.MEIE`, and holds the claimed source ID until the handler executes `mret`. It serialises all external interrupts onto the core's one trap path: one claim in flight, no preemption.

## Interface
Parameters:
- `N_SRC`, 4, number of interrupt sources (2..16).
- `ID_W`, `$clog2(N_SRC)`, width of source ID.

Ports:
- `clock`  in  1  core clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_src`  in  N_SRC  interrupt lines, synchronous to `clock`, rising-edge significant.
- `en_we`  in  1  write strobe for enable mask.
- `en_wdata`  in  N_SRC  new enable mask.
- `int_ack`  in  1  core took the trap this cycle (CSR file trap-entry condition true).
- `ret`  in  1  `mret` retiring this cycle.
- `int_req`  out  1  interrupt request to the CSR file.
- `claim_id`  out  ID_W  ID of the claimed source; feeds `mtval`.
- `pending`  out  N_SRC  pending bits, readable by software.
- `enable`  out  N_SRC  current enable mask.
- `busy`  out  1  high in REQ or SERVICE.

## Operation
- Edge capture: `src_q` registers `irq_src`. `rise = irq_src & ~src_q`. `pending[i]` is set on `rise[i]`. It is cleared only by a successful claim (`int_ack` in REQ, for `claim_id`). Set wins over clear in the same cycle.
- `en_we` loads `enable <= en_wdata` at the clock edge. Disabled sources still capture pending.
- Candidate vector `cand = pending & enable`. Winner is the lowest set index.
- FSM states:
  - IDLE: if `|cand` → REQ, latch `claim_id <= winner`.
  - REQ: if `int_ack` → SERVICE and clear `pending[claim_id]`. Otherwise, if `enable[claim_id]` is 0 → IDLE (request withdrawn, pending kept). Otherwise stay.
  - SERVICE: on `ret` → IDLE. Nothing else is accepted.
- Claim is fixed once latched. A higher-priority arrival during REQ or SERVICE waits.
- `int_req = (state == REQ)`. `busy = (state != IDLE)`.
- `int_ack` outside REQ and `ret` outside SERVICE are ignored.
- `claim_id` holds its value through SERVICE and in IDLE until the next claim.

## Timing
- Reset values:
  - `state` = IDLE; `int_req` = 0; `busy` = 0.
  - `claim_id` = 0; `pending` = 0; `src_q` = 0.
  - `enable` = all ones.
- Latency: a rise sampled at edge E0 sets pending at E0. At E1 the FSM enters REQ, and `int_req` is high from E1 onward.
- `int_ack` sampled at edge Ea: `int_req` is low after Ea. `pending[claim_id]` is 0 after Ea unless a new rise occurs at Ea.
- `ret` at edge Er → IDLE after Er. The next claim is taken at Er+1, then `int_req` is high. Minimum 1 idle cycle between services.
- Simultaneous `en_we` clearing the claimed bit and `int_ack` in REQ: the ack wins (→ SERVICE).
- Asynchronous `reset` mid-REQ or mid-SERVICE: `int_req` drops immediately and all pending bits are lost.

## Structure
- Package `int_arb_pkg` holds:
  - state encoding localparams IDLE=2'd0, REQ=2'd1, SERVICE=2'd2;
  - `ENABLE_RST` default;
  - the `ID_W` helper function.
- Sub-module `prio_enc`: combinational fixed-priority encoder, `cand[N_SRC]` in, `id[ID_W]` and `valid` out, lowest index wins.
- The top level holds the edge capture, the pending/enable registers and the FSM.

## Test plan
- Reset, then `irq_src=4'b0100`:
  - `pending=4'b0100` after 1 edge;
  - `int_req=1` and `claim_id=2` after 2 edges;
  - `int_ack` → `int_req=0`, `pending=0`;
  - `ret` → `busy=0`.
- Rises on sources 3 and 1 at the same edge:
  - `claim_id=1` first;
  - after ack+ret, `claim_id=3` claimed 1 edge later.
- Claim source 2, then raise source 0 during SERVICE:
  - no `int_req` until `ret`;
  - then `claim_id=0`.
- In REQ for source 1, write `enable=4'b1101`: → IDLE, `int_req=0`, `pending[1]` still 1. Re-enable → REQ again.
- `int_ack` coinciding with a new rise on the claimed source 2: → SERVICE with `pending[2]=1`; reclaimed after `ret`.
- Assert `reset` in SERVICE with `pending=4'b1010`: all outputs go to reset values without a clock edge; `enable=4'b1111`.

Source files
------------

// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM encoding, enable reset value, ID width helper.
package int_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Wide enough for the largest supported source count; sliced to N_SRC at use.
  localparam logic [15:0] ENABLE_RST = 16'hFFFF;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/int_arbiter_if.sv
// Arbiter-facing bundle: source lines, enable writes and trap handshake in; request, claim and status out.
interface int_arbiter_if
  import int_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = id_w(N_SRC)
);

  logic [N_SRC-1:0] irq_src;
  logic             en_we;
  logic [N_SRC-1:0] en_wdata;
  logic             int_ack;
  logic             ret;
  logic             int_req;
  logic [ID_W-1:0]  claim_id;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] enable;
  logic             busy;

  // Core/CSR side.
  modport master (
    output irq_src, en_we, en_wdata, int_ack, ret,
    input  int_req, claim_id, pending, enable, busy
  );

  // Arbiter side.
  modport slave (
    input  irq_src, en_we, en_wdata, int_ack, ret,
    output int_req, claim_id, pending, enable, busy
  );

endinterface

// File: rtl/int_arbiter_prio_enc.sv
// Fixed-priority encoder, lowest set index wins; purely combinational, zero latency.
module prio_enc #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_SRC-1:0] cand,
  output logic [ID_W-1:0]  id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Edge-captured, maskable interrupt arbiter; one claim in flight from request to mret, no preemption.
// Rise to int_req is two edges; a stalled int_ack simply holds REQ until it arrives or the source is disabled.
module int_arbiter
  import int_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = id_w(N_SRC)
) (
  input logic         clock,
  input logic         reset,
  int_arbiter_if.slave bus
);

  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  claim_q;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  logic             claim_ld;
  logic             ack_ok;
  state_t           state_q;
  state_t           state_d;

  assign rise = bus.irq_src & ~src_q;
  assign cand = pending_q & enable_q;
  assign clr  = ack_ok ? (N_SRC'(1) << claim_q) : '0;

  prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .cand  (cand),
    .id    (win_id),
    .valid (win_vld)
  );

  always_comb begin
    state_d  = state_q;
    claim_ld = 1'b0;
    ack_ok   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = REQ;
          claim_ld = 1'b1;
        end
      end
      REQ: begin
        // Ack takes precedence over a same-cycle mask write withdrawing the claim.
        if (bus.int_ack) begin
          state_d = SERVICE;
          ack_ok  = 1'b1;
        end else if (!enable_q[claim_q]) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (bus.ret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q     <= '0;
      pending_q <= '0;
      enable_q  <= ENABLE_RST[N_SRC-1:0];
      claim_q   <= '0;
    end else begin
      src_q     <= bus.irq_src;
      // A rise on the source being acked re-arms it rather than being lost.
      pending_q <= (pending_q & ~clr) | rise;
      if (bus.en_we) begin
        enable_q <= bus.en_wdata;
      end
      if (claim_ld) begin
        claim_q <= win_id;
      end
    end
  end

  assign bus.int_req  = (state_q == REQ);
  assign bus.busy     = (state_q != IDLE);
  assign bus.claim_id = claim_q;
  assign bus.pending  = pending_q;
  assign bus.enable   = enable_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Directed bench for int_arbiter: hand-computed expectations checked with immediate assertions.
module tb_int_arbiter;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  int_arbiter_if #(.N_SRC(4), .ID_W(2)) bus ();

  int_arbiter #(.N_SRC(4), .ID_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b1;
    bus.irq_src  = 4'b0000;
    bus.en_we    = 1'b0;
    bus.en_wdata = 4'b0000;
    bus.int_ack  = 1'b0;
    bus.ret      = 1'b0;

    // Reset values
    #12;
    chk("rst_int_req", 16'(bus.int_req), 16'd0);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_claim", 16'(bus.claim_id), 16'd0);
    chk("rst_pending", 16'(bus.pending), 16'h0);
    chk("rst_enable", 16'(bus.enable), 16'hF);
    reset = 1'b0;
    tick();

    // Single source 2: capture, request, ack, return
    bus.irq_src = 4'b0100;
    tick();
    chk("t1_pending", 16'(bus.pending), 16'b0100);
    chk("t1_req_early", 16'(bus.int_req), 16'd0);
    tick();
    chk("t1_int_req", 16'(bus.int_req), 16'd1);
    chk("t1_claim", 16'(bus.claim_id), 16'd2);
    chk("t1_busy", 16'(bus.busy), 16'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("t1_ack_req", 16'(bus.int_req), 16'd0);
    chk("t1_ack_pend", 16'(bus.pending), 16'h0);
    chk("t1_svc_busy", 16'(bus.busy), 16'd1);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    chk("t1_ret_busy", 16'(bus.busy), 16'd0);
    bus.irq_src = 4'b0000;
    tick();

    // Simultaneous rises on 3 and 1: 1 wins, 3 follows one edge after ret
    bus.irq_src = 4'b1010;
    tick();
    chk("t2_pending", 16'(bus.pending), 16'b1010);
    tick();
    chk("t2_claim1", 16'(bus.claim_id), 16'd1);
    chk("t2_req1", 16'(bus.int_req), 16'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("t2_pend_after_ack", 16'(bus.pending), 16'b1000);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    chk("t2_idle_gap", 16'(bus.int_req), 16'd0);
    chk("t2_idle_busy", 16'(bus.busy), 16'd0);
    tick();
    chk("t2_req3", 16'(bus.int_req), 16'd1);
    chk("t2_claim3", 16'(bus.claim_id), 16'd3);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.ret     = 1'b1;
    tick();
    bus.ret = 1'b0;
    chk("t2_pend_clear", 16'(bus.pending), 16'h0);
    bus.irq_src = 4'b0000;
    tick();

    // Higher-priority arrival during SERVICE waits for ret
    bus.irq_src = 4'b0100;
    tick();
    tick();
    chk("t3_claim2", 16'(bus.claim_id), 16'd2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.irq_src = 4'b0101;
    tick();
    chk("t3_pend0", 16'(bus.pending), 16'b0001);
    chk("t3_no_req_a", 16'(bus.int_req), 16'd0);
    tick();
    chk("t3_no_req_b", 16'(bus.int_req), 16'd0);
    chk("t3_claim_hold", 16'(bus.claim_id), 16'd2);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    chk("t3_idle", 16'(bus.int_req), 16'd0);
    tick();
    chk("t3_req0", 16'(bus.int_req), 16'd1);
    chk("t3_claim0", 16'(bus.claim_id), 16'd0);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.ret     = 1'b1;
    tick();
    bus.ret = 1'b0;
    bus.irq_src = 4'b0000;
    tick();

    // Withdraw request by masking source 1, then re-enable
    bus.irq_src = 4'b0010;
    tick();
    tick();
    chk("t4_claim1", 16'(bus.claim_id), 16'd1);
    bus.en_we    = 1'b1;
    bus.en_wdata = 4'b1101;
    tick();
    bus.en_we = 1'b0;
    chk("t4_enable", 16'(bus.enable), 16'b1101);
    chk("t4_still_req", 16'(bus.int_req), 16'd1);
    tick();
    chk("t4_withdrawn", 16'(bus.int_req), 16'd0);
    chk("t4_wd_busy", 16'(bus.busy), 16'd0);
    chk("t4_pend_kept", 16'(bus.pending), 16'b0010);
    tick();
    chk("t4_masked_idle", 16'(bus.int_req), 16'd0);
    bus.en_we    = 1'b1;
    bus.en_wdata = 4'b1111;
    tick();
    bus.en_we = 1'b0;
    tick();
    chk("t4_rereq", 16'(bus.int_req), 16'd1);
    chk("t4_reclaim", 16'(bus.claim_id), 16'd1);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.ret     = 1'b1;
    tick();
    bus.ret = 1'b0;
    bus.irq_src = 4'b0000;
    tick();

    // Ack coincides with a fresh rise on the claimed source
    bus.irq_src = 4'b0100;
    tick();
    tick();
    chk("t5_req", 16'(bus.int_req), 16'd1);
    bus.irq_src = 4'b0000;
    tick();
    bus.irq_src = 4'b0100;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("t5_svc_busy", 16'(bus.busy), 16'd1);
    chk("t5_svc_req", 16'(bus.int_req), 16'd0);
    chk("t5_pend_set", 16'(bus.pending), 16'b0100);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    tick();
    chk("t5_rereq", 16'(bus.int_req), 16'd1);
    chk("t5_reclaim", 16'(bus.claim_id), 16'd2);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("t5_pend_clr", 16'(bus.pending), 16'h0);
    bus.ret = 1'b1;
    tick();
    bus.ret = 1'b0;
    bus.irq_src = 4'b0000;
    tick();

    // Asynchronous reset during SERVICE with pending 1010 and a cleared mask
    bus.irq_src = 4'b0100;
    tick();
    tick();
    bus.irq_src = 4'b1110;
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack  = 1'b0;
    bus.en_we    = 1'b1;
    bus.en_wdata = 4'b0000;
    tick();
    bus.en_we = 1'b0;
    chk("t6_svc_pend", 16'(bus.pending), 16'b1010);
    chk("t6_svc_busy", 16'(bus.busy), 16'd1);
    chk("t6_enable0", 16'(bus.enable), 16'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_req", 16'(bus.int_req), 16'd0);
    chk("t6_rst_busy", 16'(bus.busy), 16'd0);
    chk("t6_rst_claim", 16'(bus.claim_id), 16'd0);
    chk("t6_rst_pend", 16'(bus.pending), 16'h0);
    chk("t6_rst_enable", 16'(bus.enable), 16'hF);
    #10;
    reset = 1'b0;
    bus.irq_src = 4'b0000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
